// File: rtl/keycode_pkg.sv
// Shared constants, scan-state encoding and helpers for the keycode event tracker.
package keycode_pkg;

  localparam logic [7:0] KEY_NONE     = 8'h00;
  localparam logic [7:0] KEY_ROLLOVER = 8'h01;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SCAN_PRESS,
    SCAN_REL,
    COMMIT
  } scan_state_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/key_event_fifo.sv
// Synchronous event FIFO: head is read straight from the storage registers, so a word
// pushed into an empty FIFO is presented on the next cycle. DEPTH must be a power of two.
module key_event_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic                       valid,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       drop
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic             do_pop, do_push;

  assign valid   = (count != '0);
  assign do_pop  = pop && valid;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push = push && ((count < CW'(DEPTH)) || do_pop);
  assign drop    = push && !do_push;
  assign head    = mem[rd_ptr];

  // NOTE: storage is deliberately not reset; only pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/keycode_event_tracker.sv
// Turns HID keycode snapshots into a buffered stream of press/release events.
// Optional auto-repeat of a single held key is enabled with `define KEYCODE_TYPEMATIC_EN.
module keycode_event_tracker
  import keycode_pkg::*;
#(
  parameter int NUM_SLOTS     = 6,
  parameter int KEY_W         = 8,
  parameter int FIFO_DEPTH    = 16,
  parameter int REPEAT_DELAY  = 25000000,
  parameter int REPEAT_PERIOD = 5000000
) (
  input  logic                            clk_clk,
  input  logic                            reset_reset_n,
  input  logic [NUM_SLOTS*KEY_W-1:0]      keycode_in,
  input  logic                            report_stb,
  output logic                            evt_valid,
  input  logic                            evt_ready,
  output logic [KEY_W-1:0]                evt_code,
  output logic                            evt_press,
  output logic                            evt_repeat,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] evt_count,
  output logic                            overflow,
  input  logic                            overflow_clr,
  output logic                            busy,
  output logic                            any_key_down
);
  localparam int IW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam logic [KEY_W-1:0] K_NONE     = KEY_W'(KEY_NONE);
  localparam logic [KEY_W-1:0] K_ROLLOVER = KEY_W'(KEY_ROLLOVER);

  typedef struct packed {
    logic [KEY_W-1:0] code;
    logic             press;
    logic             is_repeat;
  } evt_t;

  scan_state_e                state, state_nxt;
  logic [NUM_SLOTS*KEY_W-1:0] pending;
  logic                       pending_valid;
  logic [KEY_W-1:0]           cur  [NUM_SLOTS];
  logic [KEY_W-1:0]           prev [NUM_SLOTS];
  logic [IW-1:0]              idx;
  logic                       idx_last, load_en;
  logic [KEY_W-1:0]           scan_code;
  logic                       scan_seen, scan_hit, scan_push;
  logic                       has_rollover, snap_diff;
  logic                       rpt_push;
  logic [KEY_W-1:0]           rpt_code;
  logic                       fifo_push, fifo_drop;
  evt_t                       push_evt, head_evt;

  assign idx_last = (idx == IW'(NUM_SLOTS - 1));
  assign load_en  = (state == IDLE) && pending_valid;

  // ---------------- scan FSM ----------------
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) state <= IDLE;
    else                state <= state_nxt;
  end

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:       if (pending_valid) state_nxt = LOAD;
      LOAD:       state_nxt = has_rollover ? IDLE : SCAN_PRESS;
      SCAN_PRESS: if (idx_last) state_nxt = SCAN_REL;
      SCAN_REL:   if (idx_last) state_nxt = COMMIT;
      COMMIT:     state_nxt = IDLE;
      default:    state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != IDLE);
    scan_push = ((state == SCAN_PRESS) || (state == SCAN_REL)) && scan_hit;
  end

  // ---------------- snapshot datapath ----------------
  // NOTE: sequential state uses non-blocking assignments; blocking is kept to always_comb.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      pending       <= '0;
      pending_valid <= 1'b0;
      idx           <= '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        cur[i]  <= K_NONE;
        prev[i] <= K_NONE;
      end
    end else begin
      // A fresh strobe always wins, so an unconsumed report is simply overwritten.
      if (report_stb) begin
        pending       <= keycode_in;
        pending_valid <= 1'b1;
      end else if (load_en) begin
        pending_valid <= 1'b0;
      end
      if (load_en) begin
        for (int i = 0; i < NUM_SLOTS; i++) cur[i] <= pending[i*KEY_W +: KEY_W];
      end
      if ((state == SCAN_PRESS) || (state == SCAN_REL)) idx <= idx_last ? '0 : idx + IW'(1);
      else                                              idx <= '0;
      if (state == COMMIT) begin
        for (int i = 0; i < NUM_SLOTS; i++) prev[i] <= cur[i];
      end
    end
  end

  // Press scan walks cur against prev; release scan walks prev against cur.
  always_comb begin
    scan_code = (state == SCAN_REL) ? prev[idx] : cur[idx];
    scan_seen = 1'b0;
    for (int j = 0; j < NUM_SLOTS; j++) begin
      if (((state == SCAN_REL) ? cur[j] : prev[j]) == scan_code) scan_seen = 1'b1;
      if ((j < int'(idx)) && (((state == SCAN_REL) ? prev[j] : cur[j]) == scan_code))
        scan_seen = 1'b1;
    end
    scan_hit = (scan_code != K_NONE) && !scan_seen;
  end

  always_comb begin
    has_rollover = 1'b0;
    any_key_down = 1'b0;
    snap_diff    = 1'b0;
    for (int j = 0; j < NUM_SLOTS; j++) begin
      if (cur[j] == K_ROLLOVER) has_rollover = 1'b1;
      if (prev[j] != K_NONE)    any_key_down = 1'b1;
      if (cur[j] != prev[j])    snap_diff    = 1'b1;
    end
  end

  // ---------------- auto-repeat ----------------
`ifdef KEYCODE_TYPEMATIC_EN
  localparam int CNT_W = $clog2(max_u(REPEAT_DELAY, REPEAT_PERIOD) + 1);

  logic [CNT_W-1:0] rpt_cnt, rpt_target;
  logic             rpt_first, rpt_single, rpt_conflict, rpt_due;

  always_comb begin
    rpt_code     = K_NONE;
    rpt_conflict = 1'b0;
    for (int j = 0; j < NUM_SLOTS; j++) begin
      if (prev[j] != K_NONE) begin
        if (rpt_code == K_NONE)     rpt_code     = prev[j];
        else if (prev[j] != rpt_code) rpt_conflict = 1'b1;
      end
    end
    rpt_single = (rpt_code != K_NONE) && !rpt_conflict;
    rpt_target = rpt_first ? CNT_W'(REPEAT_DELAY - 1) : CNT_W'(REPEAT_PERIOD - 1);
    rpt_due    = rpt_single && (rpt_cnt == rpt_target);
    rpt_push   = rpt_due && (state == IDLE);
  end

  // A due repeat holds the counter until the scan FSM is back in IDLE.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      rpt_cnt   <= '0;
      rpt_first <= 1'b1;
    end else if (((state == COMMIT) && snap_diff) || !rpt_single) begin
      rpt_cnt   <= '0;
      rpt_first <= 1'b1;
    end else if (rpt_due) begin
      if (state == IDLE) begin
        rpt_cnt   <= '0;
        rpt_first <= 1'b0;
      end
    end else begin
      rpt_cnt <= rpt_cnt + CNT_W'(1);
    end
  end

  assign evt_repeat = head_evt.is_repeat;
`else
  logic unused_cfg;

  assign rpt_push   = 1'b0;
  assign rpt_code   = K_NONE;
  assign evt_repeat = 1'b0;
  assign unused_cfg = (REPEAT_DELAY != REPEAT_PERIOD) ^ head_evt.is_repeat;
`endif

  // ---------------- event FIFO ----------------
  assign fifo_push = scan_push || rpt_push;
  assign push_evt  = scan_push ? evt_t'{code: scan_code, press: (state == SCAN_PRESS), is_repeat: 1'b0}
                               : evt_t'{code: rpt_code,  press: 1'b1,                  is_repeat: 1'b1};

  key_event_fifo #(
    .WIDTH ($bits(evt_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk_clk),
    .rst_n     (reset_reset_n),
    .push      (fifo_push),
    .push_data (push_evt),
    .pop       (evt_ready),
    .head      (head_evt),
    .valid     (evt_valid),
    .count     (evt_count),
    .drop      (fifo_drop)
  );

  assign evt_code  = head_evt.code;
  assign evt_press = head_evt.press;

  // Setting wins over clearing when both happen in one cycle.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n)    overflow <= 1'b0;
    else if (fifo_drop)    overflow <= 1'b1;
    else if (overflow_clr) overflow <= 1'b0;
  end

endmodule

// File: tb/tb_keycode_event_tracker.sv
// Scoreboard bench: a set-based reference model predicts the event stream per report and a
// monitor pops predictions as the DUT hands events over. Typematic checks under KEYCODE_TYPEMATIC_EN.
module tb_keycode_event_tracker;
  localparam int N     = 6;
  localparam int KW    = 8;
  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH + 1);

  typedef logic [KW-1:0] key_t;
  typedef logic [N*KW-1:0] rep_t;
  typedef struct packed {
    logic [KW-1:0] code;
    logic          press;
    logic          rpt;
  } ev_t;

  logic          clk, rst_n;
  rep_t          keycode_in;
  logic          report_stb, evt_valid, evt_ready, evt_press, evt_repeat;
  logic [KW-1:0] evt_code;
  logic [CW-1:0] evt_count;
  logic          overflow, overflow_clr, busy, any_key_down;

  int   vectors = 0, miscompares = 0;
  int   ready_mode = 1;       // 0 hold low, 1 hold high, 2 random
  bit   repeat_mode = 1'b0;   // monitor stands aside while a test watches events itself
  bit   exp_overflow = 1'b0;
  int   cyc = 0;
  ev_t  exp_q[$];
  key_t model_prev[$];

  keycode_event_tracker #(
    .NUM_SLOTS (N), .KEY_W (KW), .FIFO_DEPTH (DEPTH)
`ifdef KEYCODE_TYPEMATIC_EN
    , .REPEAT_DELAY (10), .REPEAT_PERIOD (4)
`endif
  ) dut (
    .clk_clk (clk), .reset_reset_n (rst_n), .keycode_in (keycode_in), .report_stb (report_stb),
    .evt_valid (evt_valid), .evt_ready (evt_ready), .evt_code (evt_code), .evt_press (evt_press),
    .evt_repeat (evt_repeat), .evt_count (evt_count), .overflow (overflow),
    .overflow_clr (overflow_clr), .busy (busy), .any_key_down (any_key_down)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  function automatic bit has(input key_t q[$], input key_t k);
    foreach (q[i]) if (q[i] == k) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit model_down();
    foreach (model_prev[i]) if (model_prev[i] != 8'h00) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_push(input ev_t e);
    if (exp_q.size() < DEPTH) exp_q.push_back(e);
    else                      exp_overflow = 1'b1;
  endtask

  // Presses: new distinct codes, in slot order. Releases: vanished distinct codes, in slot order.
  task automatic model_report(input rep_t v);
    key_t cur[$];
    key_t done[$];
    for (int i = 0; i < N; i++) cur.push_back(v[i*KW +: KW]);
    if (has(cur, 8'h01)) return;
    foreach (cur[i])
      if (cur[i] != 8'h00 && !has(model_prev, cur[i]) && !has(done, cur[i])) begin
        model_push('{code: cur[i], press: 1'b1, rpt: 1'b0});
        done.push_back(cur[i]);
      end
    done.delete();
    foreach (model_prev[i])
      if (model_prev[i] != 8'h00 && !has(cur, model_prev[i]) && !has(done, model_prev[i])) begin
        model_push('{code: model_prev[i], press: 1'b0, rpt: 1'b0});
        done.push_back(model_prev[i]);
      end
    model_prev = cur;
  endtask

  function automatic rep_t mk(input key_t k0, k1, k2, k3, k4, k5);
    return {k5, k4, k3, k2, k1, k0};
  endfunction

  function automatic rep_t rand_report();
    rep_t v;
    key_t k, other;
    int   nz, j;
    bit   multi;
    for (int i = 0; i < N; i++) begin
      int r = $urandom_range(0, 9);
      v[i*KW +: KW] = (r < 4) ? 8'h00 : key_t'(8'h04 + r - 4);
    end
    if ($urandom_range(0, 19) == 0) v[$urandom_range(0, N-1)*KW +: KW] = 8'h01;
`ifdef KEYCODE_TYPEMATIC_EN
    // Keep random snapshots away from the single-key case so no auto-repeat fires here.
    k = 8'h00; multi = 1'b0; nz = 0;
    for (int i = 0; i < N; i++)
      if (v[i*KW +: KW] != 8'h00) begin
        nz++;
        if (k == 8'h00) k = v[i*KW +: KW];
        else if (v[i*KW +: KW] != k) multi = 1'b1;
      end
    if (nz != 0 && !multi) begin
      other = (k == 8'h04) ? 8'h05 : 8'h04;
      j = 0;
      for (int i = N - 1; i >= 0; i--) if (v[i*KW +: KW] != k) j = i;
      v[j*KW +: KW] = other;
    end
`else
    k = 8'h00; other = 8'h00; nz = 0; j = 0; multi = 1'b0;
`endif
    return v;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic strobe(input rep_t v, input bit modeled);
    keycode_in = v;
    report_stb = 1'b1;
    if (modeled) model_report(v);
    tick();
    report_stb = 1'b0;
  endtask

  task automatic wait_quiet();
    int idle = 0;
    for (int k = 0; k < 400; k++) begin
      tick();
      if (!busy) idle++;
      else       idle = 0;
      if (idle >= 3) return;
    end
    check("busy_timeout", busy, 0);
  endtask

  task automatic drain();
    for (int k = 0; k < 1000 && exp_q.size() != 0; k++) tick();
    check("drain_empty", exp_q.size(), 0);
  endtask

  // ---------------- ready driver and scoreboard monitor ----------------
  initial begin
    evt_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       evt_ready = 1'b0;
        1:       evt_ready = 1'b1;
        default: evt_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  initial begin
    ev_t e;
    bit  skip;
    forever begin
      @(negedge clk);
      skip = repeat_mode;
`ifdef KEYCODE_TYPEMATIC_EN
      skip = skip || evt_repeat;
`endif
      if (rst_n && evt_valid && evt_ready && !skip) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_evt: got code=0x%0h press=%0d repeat=%0d, expected none",
                   evt_code, evt_press, evt_repeat);
        end else begin
          e = exp_q.pop_front();
          check("evt", {evt_code, evt_press, evt_repeat}, e);
        end
      end
    end
  end

  // ---------------- test sequence ----------------
  initial begin
    rep_t v;
    rst_n = 1'b0; keycode_in = '0; report_stb = 1'b0; overflow_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", evt_valid, 0);
    check("rst_count", evt_count, 0);
    check("rst_overflow", overflow, 0);
    check("rst_down", any_key_down, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    tick();

    // Single press then release.
    strobe(mk(8'h04, 0, 0, 0, 0, 0), 1'b1);
    wait_quiet();
    check("down_after_press", any_key_down, 1);
    strobe('0, 1'b1);
    wait_quiet();
    check("down_after_release", any_key_down, 0);
    drain();

    // Overlapping reports with a duplicated slot.
    strobe(mk(8'h04, 8'h05, 0, 0, 0, 0), 1'b1);
    wait_quiet();
    strobe(mk(8'h05, 8'h06, 8'h06, 0, 0, 0), 1'b1);
    wait_quiet();
    drain();

    // Rollover report is discarded; the following empty report releases the kept snapshot.
    strobe(mk(8'h07, 0, 0, 8'h01, 0, 0), 1'b1);
    wait_quiet();
    check("rollover_busy", busy, 0);
    check("rollover_count", evt_count, 0);
    check("rollover_down", any_key_down, 1);
    strobe('0, 1'b1);
    wait_quiet();
    drain();

    // Randomized reports, some overwritten while the scan is busy.
    ready_mode = 2;
    for (int it = 0; it < 40; it++) begin
      for (int k = 0; k < 500 && exp_q.size() > 4; k++) tick();
      if ($urandom_range(0, 4) == 0) begin
        ready_mode = 1;
        for (int k = 0; k < 500 && exp_q.size() != 0; k++) tick();
        strobe(rand_report(), 1'b1);
        repeat (3) tick();
        strobe(rand_report(), 1'b0);
        strobe(rand_report(), 1'b1);
        wait_quiet();
        ready_mode = 2;
      end else begin
        strobe(rand_report(), 1'b1);
        wait_quiet();
      end
      check("rand_down", any_key_down, model_down());
    end
    ready_mode = 1;
    drain();
    check("rand_overflow", overflow, exp_overflow);

    // Overflow: stall the consumer and push more events than the FIFO holds.
    strobe('0, 1'b1);
    wait_quiet();
    drain();
    check("pre_ovf_count", evt_count, 0);
    ready_mode = 0;
    repeat (3) tick();
    strobe(mk(8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15), 1'b1);
    wait_quiet();
    strobe(mk(8'h16, 8'h17, 8'h18, 8'h19, 8'h1A, 8'h1B), 1'b1);
    wait_quiet();
    check("ovf_count", evt_count, exp_q.size());
    check("ovf_full", evt_count, DEPTH);
    check("ovf_flag", overflow, exp_overflow);
    overflow_clr = 1'b1;
    tick();
    overflow_clr = 1'b0;
    check("ovf_clear", overflow, 0);
    exp_overflow = 1'b0;
    ready_mode = 1;
    drain();

    // Reset in the middle of a scan discards everything, including the snapshot.
    strobe(mk(8'h20, 8'h21, 8'h22, 0, 0, 0), 1'b1);
    repeat (4) tick();
    rst_n = 1'b0;
    #1;
    check("midrst_valid", evt_valid, 0);
    check("midrst_count", evt_count, 0);
    check("midrst_busy", busy, 0);
    check("midrst_down", any_key_down, 0);
    exp_q.delete();
    model_prev.delete();
    tick();
    rst_n = 1'b1;
    tick();
    strobe(mk(8'h22, 8'h23, 0, 0, 0, 0), 1'b1);
    wait_quiet();
    strobe('0, 1'b1);
    wait_quiet();
    drain();

`ifdef KEYCODE_TYPEMATIC_EN
    begin
      int  t[4];
      ev_t got[4];
      int  n = 0, nrel = 0;
      ev_t rel = '0;
      repeat_mode = 1'b1;
      strobe(mk(8'h1A, 0, 0, 0, 0, 0), 1'b1);
      for (int k = 0; k < 200 && n < 4; k++) begin
        @(negedge clk);
        if (evt_valid && evt_ready) begin
          t[n]   = cyc;
          got[n] = {evt_code, evt_press, evt_repeat};
          n++;
        end
      end
      check("rpt_events", n, 4);
      check("rpt_press", got[0], {8'h1A, 1'b1, 1'b0});
      for (int i = 1; i < 4; i++) check("rpt_evt", got[i], {8'h1A, 1'b1, 1'b1});
      check("rpt_first_gap", t[1] - t[0], 2 * N + 10);
      check("rpt_gap2", t[2] - t[1], 4);
      check("rpt_gap3", t[3] - t[2], 4);
      keycode_in = '0;
      report_stb = 1'b1;
      model_report('0);
      tick();
      report_stb = 1'b0;
      for (int k = 0; k < 60; k++) begin
        @(negedge clk);
        if (evt_valid && evt_ready) begin
          nrel++;
          rel = {evt_code, evt_press, evt_repeat};
        end
      end
      check("rpt_stop_events", nrel, 1);
      check("rpt_release", rel, {8'h1A, 1'b0, 1'b0});
      exp_q.delete();
      tick();
      repeat_mode = 1'b0;
    end
`endif

    check("end_count", evt_count, 0);
    check("end_overflow", overflow, 0);
    check("end_queue", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
